fifo_ku_rst_ctrl: RTL

Single-clock reset and enable sequencer placed in front of a Kintex UltraScale FIFO36E2 running with CLOCK_DOMAINS "COMMON".
- Enforces the primitive's reset protocol: enables low before reset, reset held a minimum number of cycles, no access while RDRSTBUSY/WRRSTBUSY are high.
- Gates user wr_en/rd_en against full/empty.
- Accepts a synchronous soft-flush request and reports readiness and reset errors.

---
 rtl/fifo_ku_ctrl_pkg.sv | 26 ++
 rtl/fifo_ku_cyc_timer.sv | 37 +++
 rtl/fifo_ku_rst_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fifo_ku_ctrl_pkg.sv
// Shared types and defaults for the FIFO36E2 reset/enable sequencer.
package fifo_ku_ctrl_pkg;

    typedef enum logic [1:0] {
        PRE    = 2'd0,
        ASSERT = 2'd1,
        WAIT   = 2'd2,
        RUN    = 2'd3
    } state_e;

    localparam int unsigned PRE_CYC_DEF = 4;
    localparam int unsigned RST_CYC_DEF = 5;
    localparam int unsigned TIMEOUT_DEF = 256;

    // Wide enough to reach the largest of the three phase lengths.
    function automatic int unsigned timer_w(input int unsigned pre_cyc,
                                            input int unsigned rst_cyc,
                                            input int unsigned tmo_cyc);
        int unsigned m;
        m = pre_cyc;
        if (rst_cyc > m) m = rst_cyc;
        if (tmo_cyc > m) m = tmo_cyc;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/fifo_ku_cyc_timer.sv
// Loadable, clearable, saturating up-counter with a terminal-match flag.
module fifo_ku_cyc_timer #(
    parameter int unsigned W = 9
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic [W-1:0] term_i,
    output logic         match_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_o = (cnt_q == term_i);

endmodule

// File: rtl/fifo_ku_rst_ctrl.sv
// Reset/enable sequencer for a common-clock FIFO36E2.
// Optional macro FIFO_KU_RST_STAT_EN adds the rst_cnt reset-entry counter.
module fifo_ku_rst_ctrl
    import fifo_ku_ctrl_pkg::*;
#(
    parameter int unsigned PRE_CYC = PRE_CYC_DEF,
    parameter int unsigned RST_CYC = RST_CYC_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        soft_rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic        fifo_full,
    input  logic        fifo_empty,
    input  logic        wr_rst_busy,
    input  logic        rd_rst_busy,
    output logic        fifo_rst,
    output logic        fifo_wren,
    output logic        fifo_rden,
    output logic        full,
    output logic        empty,
    output logic        ready,
`ifdef FIFO_KU_RST_STAT_EN
    output logic [15:0] rst_cnt,
`endif
    output logic        rst_err
);

    localparam int unsigned TW = timer_w(PRE_CYC, RST_CYC, TIMEOUT);

    state_e          state_q, state_d;
    logic            fifo_rst_q, ready_q, rst_err_q, rst_err_d;
    logic [TW-1:0]   term;
    logic            tmatch;
    logic            tclr;

    always_comb begin
        case (state_q)
            PRE:     term = TW'(PRE_CYC - 1);
            ASSERT:  term = TW'(RST_CYC - 1);
            default: term = TW'(TIMEOUT - 1);
        endcase
    end

    assign tclr = (state_d != state_q);

    fifo_ku_cyc_timer #(
        .W (TW)
    ) u_timer (
        .clk_i      (clock),
        .rst_ni     (rst_n),
        .clr_i      (tclr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .term_i     (term),
        .match_o    (tmatch)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ASSERT;
            fifo_rst_q <= 1'b1;
            ready_q    <= 1'b0;
            rst_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fifo_rst_q <= (state_d == ASSERT);
            ready_q    <= (state_d == RUN);
            rst_err_q  <= rst_err_d;
        end
    end

    // Busy flags are only meaningful once RST has been released.
    always_comb begin
        state_d   = state_q;
        rst_err_d = rst_err_q;
        case (state_q)
            PRE:    if (tmatch) state_d = ASSERT;
            ASSERT: if (tmatch) state_d = WAIT;
            WAIT: begin
                if (!wr_rst_busy && !rd_rst_busy) begin
                    state_d = RUN;
                end else if (tmatch) begin
                    state_d   = PRE;
                    rst_err_d = 1'b1;
                end
            end
            RUN:    if (soft_rst) state_d = PRE;
            default: state_d = ASSERT;
        endcase
    end

    always_comb begin
        fifo_rst  = fifo_rst_q;
        ready     = ready_q;
        rst_err   = rst_err_q;
        fifo_wren = wr_en & ~fifo_full & ready_q;
        fifo_rden = rd_en & ~fifo_empty & ready_q;
        full      = fifo_full | ~ready_q;
        empty     = fifo_empty | ~ready_q;
    end

`ifdef FIFO_KU_RST_STAT_EN
    logic [15:0] rst_cnt_q;
    logic        ent_q;

    // ent_q marks the first cycle of any state, including the one after rst_n release.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rst_cnt_q <= '0;
            ent_q     <= 1'b1;
        end else begin
            ent_q <= (state_d != state_q);
            if (state_q == ASSERT && ent_q && rst_cnt_q != '1) begin
                rst_cnt_q <= rst_cnt_q + 16'd1;
            end
        end
    end

    assign rst_cnt = rst_cnt_q;
`endif

endmodule
